// File: rtl/mct_scheduler.sv
// Memory-cycle-time scheduler: one-hot timing-pulse ring with per-MCT arbitration
// among counter, interrupt and instruction cycles. Define MCT_COUNT_EN to add mct_count.
module mct_scheduler #(
  parameter int NUM_PULSES  = 12,
  parameter int NUM_CNT_REQ = 4,
  parameter int NUM_INT     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic [NUM_CNT_REQ-1:0] cnt_req,
  input  logic [NUM_INT-1:0]     int_req,
  input  logic                   int_inhibit,
  output logic [NUM_PULSES-1:0]  tp,
  output logic                   mct_start,
  output logic [1:0]             cycle_type,
  output logic [2:0]             grant_id,
  output logic [NUM_CNT_REQ-1:0] cnt_ack,
  output logic [NUM_INT-1:0]     int_ack,
  output logic                   busy
`ifdef MCT_COUNT_EN
  ,
  output logic [15:0]            mct_count
`endif
);

  typedef enum logic {ST_STOPPED, ST_RUN} state_t;

  localparam int IDX_W = (NUM_PULSES > 2) ? $clog2(NUM_PULSES) : 1;
  localparam logic [IDX_W-1:0]       LAST    = IDX_W'(NUM_PULSES - 1);
  localparam logic [NUM_PULSES-1:0]  TP_ONE  = 1;
  localparam logic [NUM_CNT_REQ-1:0] CNT_ONE = 1;
  localparam logic [NUM_INT-1:0]     INT_ONE = 1;

  localparam logic [1:0] CT_IDLE = 2'b00;
  localparam logic [1:0] CT_INSN = 2'b01;
  localparam logic [1:0] CT_CNT  = 2'b10;
  localparam logic [1:0] CT_INT  = 2'b11;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_PULSES-1:0]  tp_q, tp_d;
  logic                   mct_start_q, mct_start_d;
  logic [1:0]             ctype_q, ctype_d;
  logic [2:0]             gid_q, gid_d;
  logic [NUM_CNT_REQ-1:0] cnt_ack_q, cnt_ack_d;
  logic [NUM_INT-1:0]     int_ack_q, int_ack_d;
  logic                   busy_q, busy_d;

  logic [NUM_CNT_REQ-1:0] cnt_m;
  logic [NUM_INT-1:0]     int_m;
  logic                   last_pulse;
  logic                   start_mct;

  // Lowest set bit wins; callers guarantee at least one bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  always_comb begin
    // The line being acked this clk is still requesting; hide it from arbitration.
    cnt_m       = cnt_req & ~cnt_ack_q;
    int_m       = int_req & ~int_ack_q;
    last_pulse  = (state_q == ST_RUN) && (idx_q == LAST);
    start_mct   = 1'b0;
    state_d     = state_q;
    idx_d       = idx_q;
    ctype_d     = ctype_q;
    gid_d       = gid_q;
    busy_d      = busy_q;
    cnt_ack_d   = '0;
    int_ack_d   = '0;
    mct_start_d = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        if (run || step) start_mct = 1'b1;
      end
      ST_RUN: begin
        if (last_pulse) begin
          if (run) begin
            start_mct = 1'b1;
          end else begin
            state_d = ST_STOPPED;
            idx_d   = '0;
            ctype_d = CT_IDLE;
            gid_d   = 3'd0;
            busy_d  = 1'b0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          if (idx_d == LAST) begin
            if (ctype_q == CT_CNT) cnt_ack_d = CNT_ONE << gid_q;
            if (ctype_q == CT_INT) int_ack_d = INT_ONE << gid_q;
          end
        end
      end
      default: state_d = ST_STOPPED;
    endcase

    if (start_mct) begin
      state_d     = ST_RUN;
      idx_d       = '0;
      busy_d      = 1'b1;
      mct_start_d = 1'b1;
      if (|cnt_m) begin
        ctype_d = CT_CNT;
        gid_d   = lowest_set(8'(cnt_m));
      end else if (!int_inhibit && |int_m) begin
        ctype_d = CT_INT;
        gid_d   = lowest_set(8'(int_m));
      end else begin
        ctype_d = CT_INSN;
        gid_d   = 3'd0;
      end
    end

    tp_d = (state_d == ST_RUN) ? (TP_ONE << idx_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STOPPED;
      idx_q       <= '0;
      tp_q        <= '0;
      mct_start_q <= 1'b0;
      ctype_q     <= CT_IDLE;
      gid_q       <= 3'd0;
      cnt_ack_q   <= '0;
      int_ack_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tp_q        <= tp_d;
      mct_start_q <= mct_start_d;
      ctype_q     <= ctype_d;
      gid_q       <= gid_d;
      cnt_ack_q   <= cnt_ack_d;
      int_ack_q   <= int_ack_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MCT_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           count_q <= 16'd0;
    else if (last_pulse) count_q <= count_q + 16'd1;
  end

  assign mct_count = count_q;
`endif

  assign tp         = tp_q;
  assign mct_start  = mct_start_q;
  assign cycle_type = ctype_q;
  assign grant_id   = gid_q;
  assign cnt_ack    = cnt_ack_q;
  assign int_ack    = int_ack_q;
  assign busy       = busy_q;

endmodule
